core_rd_arbiter: RTL and testbench

//  Shares one AXI4-Lite read port (shared instruction/data memory) between two read masters:

---
 rtl/core_rd_arbiter_if.sv | 25 ++
 rtl/core_rd_arbiter.sv | 115 +++++++++++
 tb/tb_core_rd_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle shared by the arbiter's master-facing and slave-facing ports.
interface core_rd_arbiter_if #(
   parameter int unsigned AXI_AWIDTH = 4,
   parameter int unsigned AXI_DWIDTH = 32
);
   logic [AXI_AWIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [AXI_DWIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   // Issuer of read requests (core-side master, or the arbiter toward memory).
   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   // Responder to read requests (the arbiter toward a core master, or memory).
   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/core_rd_arbiter.sv
// Two-master read arbiter for one AXI4-Lite read port; one transaction in flight,
// master ARREADY is given only in the cycle its read data returns.
module core_rd_arbiter #(
   parameter int unsigned AXI_AWIDTH = 4,
   parameter int unsigned AXI_DWIDTH = 32,
   parameter int unsigned ARB_MODE   = 0
) (
   input  logic             CLK,
   input  logic             NRST,
   core_rd_arbiter_if.slave  m0,
   core_rd_arbiter_if.slave  m1,
   core_rd_arbiter_if.master s,
   output logic             GRANT,
   output logic             BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  grant_d;
   logic                  busy_d;
   logic                  rr_last_q, rr_last_d;
   logic                  arvalid_q, arvalid_d;
   logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
   logic                  win_c;
   logic                  rready_c;
   logic [1:0]            own_c;
   logic [AXI_DWIDTH-1:0] rdata_c;
   logic [1:0]            rresp_c;

   // State and registered outputs; rr_last resets to 1 so port 0 wins the first tie.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q   <= ST_IDLE;
         GRANT     <= 1'b0;
         BUSY      <= 1'b0;
         rr_last_q <= 1'b1;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
      end else begin
         state_q   <= state_d;
         GRANT     <= grant_d;
         BUSY      <= busy_d;
         rr_last_q <= rr_last_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
      end
   end

   // Next-state, arbitration and data-phase routing.
   always_comb begin
      state_d   = state_q;
      grant_d   = GRANT;
      rr_last_d = rr_last_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      rready_c  = 1'b0;
      own_c     = 2'b00;
      rdata_c   = s.rdata;
      rresp_c   = s.rresp;

      win_c = m1.arvalid;
      if (m0.arvalid && m1.arvalid) begin
         win_c = (ARB_MODE == 0) ? 1'b1 : ~rr_last_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (m0.arvalid || m1.arvalid) begin
               grant_d   = win_c;
               araddr_d  = win_c ? m1.araddr : m0.araddr;
               arvalid_d = 1'b1;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (s.arready) begin
               arvalid_d = 1'b0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            own_c    = GRANT ? 2'b10 : 2'b01;
            rready_c = GRANT ? m1.rready : m0.rready;
            if (s.rvalid && rready_c) begin
               rr_last_d = GRANT;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign s.araddr  = araddr_q;
   assign s.arvalid = arvalid_q;
   assign s.rready  = rready_c;

   // Only the data-phase owner sees the response; the other master reads all zeros.
   assign m0.rvalid  = own_c[0] & s.rvalid;
   assign m0.arready = own_c[0] & s.rvalid;
   assign m0.rdata   = own_c[0] ? rdata_c : '0;
   assign m0.rresp   = own_c[0] ? rresp_c : 2'b00;

   assign m1.rvalid  = own_c[1] & s.rvalid;
   assign m1.arready = own_c[1] & s.rvalid;
   assign m1.rdata   = own_c[1] ? rdata_c : '0;
   assign m1.rresp   = own_c[1] ? rresp_c : 2'b00;

endmodule

// File: tb/tb_core_rd_arbiter.sv
// Bench for core_rd_arbiter: fixed-priority and round-robin instances share one stimulus
// set through a select mux; per-port response queues hold what each master must receive.
module tb_core_rd_arbiter;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;

   logic CLK = 1'b0;
   logic NRST;
   always #5 CLK = ~CLK;

   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_m0 ();
   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_m1 ();
   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_s ();
   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_m0 ();
   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_m1 ();
   core_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_s ();

   logic grant_a, busy_a, grant_b, busy_b;

   core_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ARB_MODE(0)) u_dut_fp (
      .CLK   (CLK),
      .NRST  (NRST),
      .m0    (a_m0),
      .m1    (a_m1),
      .s     (a_s),
      .GRANT (grant_a),
      .BUSY  (busy_a)
   );

   core_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ARB_MODE(1)) u_dut_rr (
      .CLK   (CLK),
      .NRST  (NRST),
      .m0    (b_m0),
      .m1    (b_m1),
      .s     (b_s),
      .GRANT (grant_b),
      .BUSY  (busy_b)
   );

   // sel=0 routes stimulus to the fixed-priority instance, sel=1 to round-robin
   logic          sel;
   logic [1:0]    m_arvalid, m_rready;
   logic [AW-1:0] m_araddr [2];
   logic          s_arready, s_rvalid;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;

   assign a_m0.arvalid = !sel && m_arvalid[0];
   assign a_m1.arvalid = !sel && m_arvalid[1];
   assign b_m0.arvalid =  sel && m_arvalid[0];
   assign b_m1.arvalid =  sel && m_arvalid[1];
   assign a_m0.rready  = !sel && m_rready[0];
   assign a_m1.rready  = !sel && m_rready[1];
   assign b_m0.rready  =  sel && m_rready[0];
   assign b_m1.rready  =  sel && m_rready[1];
   assign a_m0.araddr  = m_araddr[0];
   assign a_m1.araddr  = m_araddr[1];
   assign b_m0.araddr  = m_araddr[0];
   assign b_m1.araddr  = m_araddr[1];
   assign a_s.arready  = !sel && s_arready;
   assign b_s.arready  =  sel && s_arready;
   assign a_s.rvalid   = !sel && s_rvalid;
   assign b_s.rvalid   =  sel && s_rvalid;
   assign a_s.rdata    = s_rdata;
   assign b_s.rdata    = s_rdata;
   assign a_s.rresp    = s_rresp;
   assign b_s.rresp    = s_rresp;

   logic [1:0]    m_arready, m_rvalid;
   logic [DW-1:0] m_rdata [2];
   logic [1:0]    m_rresp [2];
   logic          s_arvalid_o, s_rready_o, grant_o, busy_o;
   logic [AW-1:0] s_araddr_o;

   assign m_arready   = sel ? {b_m1.arready, b_m0.arready} : {a_m1.arready, a_m0.arready};
   assign m_rvalid    = sel ? {b_m1.rvalid, b_m0.rvalid}   : {a_m1.rvalid, a_m0.rvalid};
   assign m_rdata[0]  = sel ? b_m0.rdata : a_m0.rdata;
   assign m_rdata[1]  = sel ? b_m1.rdata : a_m1.rdata;
   assign m_rresp[0]  = sel ? b_m0.rresp : a_m0.rresp;
   assign m_rresp[1]  = sel ? b_m1.rresp : a_m1.rresp;
   assign s_arvalid_o = sel ? b_s.arvalid : a_s.arvalid;
   assign s_araddr_o  = sel ? b_s.araddr  : a_s.araddr;
   assign s_rready_o  = sel ? b_s.rready  : a_s.rready;
   assign grant_o     = sel ? grant_b : grant_a;
   assign busy_o      = sel ? busy_b  : busy_a;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } exp_t;

   typedef struct {
      int            port;
      logic [AW-1:0] addr;
      int            ar_dly;
      int            r_dly;
      int            rdy_dly;
      bit            drop;
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } vec_t;

   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   logic [DW-1:0] mem_data [16];
   logic [1:0]    mem_resp [16];
   vec_t          vecs [6];

   int n_checks;
   int n_errors;
   bit in_data;
   bit gp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic request(input int p, input logic [AW-1:0] addr,
                          input logic [DW-1:0] d, input logic [1:0] r);
      exp_t e;
      mem_data[addr] = d;
      mem_resp[addr] = r;
      m_araddr[p]    = addr;
      m_arvalid[p]   = 1'b1;
      e.data = d;
      e.resp = r;
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic check_resp(input int p);
      exp_t e;
      bit   empty;
      empty = (p == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
         n_checks++;
         n_errors++;
         $display("FAIL m%0d_unexpected_resp: got data 0x%0h with nothing expected", p, m_rdata[p]);
      end else begin
         e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         chk($sformatf("m%0d_rdata_sb", p), m_rdata[p], e.data);
         chk($sformatf("m%0d_rresp_sb", p), 32'(m_rresp[p]), 32'(e.resp));
      end
   endtask

   // Per-cycle check of every master-facing output plus S_RREADY.
   task automatic sample();
      #1;
      for (int p = 0; p < 2; p++) begin
         bit own;
         own = in_data && (int'(gp) == p);
         chk($sformatf("m%0d_rvalid", p),  32'(m_rvalid[p]),  32'(own && s_rvalid));
         chk($sformatf("m%0d_arready", p), 32'(m_arready[p]), 32'(own && s_rvalid));
         chk($sformatf("m%0d_rdata", p),   m_rdata[p], own ? s_rdata : 32'h0);
         chk($sformatf("m%0d_rresp", p),   32'(m_rresp[p]), own ? 32'(s_rresp) : 32'h0);
         if (m_rvalid[p] && m_rready[p]) check_resp(p);
      end
      chk("s_rready", 32'(s_rready_o), 32'(in_data && m_rready[gp]));
   endtask

   // Slave-side model for one transaction expected to be granted to port p.
   task automatic serve_one(input int p, input int ar_dly, input int r_dly,
                            input int rdy_dly, input bit drop);
      int            waits;
      logic [AW-1:0] addr;
      bit            pi;
      pi    = 1'(p);
      addr  = m_araddr[pi];
      waits = 0;
      while (!s_arvalid_o && waits < 20) begin
         step();
         sample();
         waits++;
      end
      chk("ar_latency", 32'(waits), 32'd1);
      if (!s_arvalid_o) return;
      chk("grant", 32'(grant_o), 32'(p));
      chk("busy_addr", 32'(busy_o), 32'd1);
      chk("s_araddr", 32'(s_araddr_o), 32'(addr));
      if (drop) m_arvalid[pi] = 1'b0;
      repeat (ar_dly) begin
         step();
         sample();
         chk("s_arvalid_hold", 32'(s_arvalid_o), 32'd1);
         chk("s_araddr_hold", 32'(s_araddr_o), 32'(addr));
      end
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      in_data   = 1'b1;
      gp        = pi;
      sample();
      chk("s_arvalid_drop", 32'(s_arvalid_o), 32'd0);
      chk("busy_data", 32'(busy_o), 32'd1);
      repeat (r_dly) begin
         step();
         sample();
      end
      for (int k = 0; k <= rdy_dly; k++) begin
         step();
         s_rvalid     = 1'b1;
         s_rdata      = mem_data[addr];
         s_rresp      = mem_resp[addr];
         m_rready[pi] = (k == rdy_dly);
         sample();
      end
      step();
      s_rvalid      = 1'b0;
      s_rdata       = '0;
      s_rresp       = 2'b00;
      m_rready[pi]  = 1'b0;
      m_arvalid[pi] = 1'b0;
      in_data       = 1'b0;
      sample();
      chk("busy_idle", 32'(busy_o), 32'd0);
      chk("s_arvalid_idle", 32'(s_arvalid_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      sel         = 1'b0;
      NRST        = 1'b0;
      m_arvalid   = 2'b00;
      m_rready    = 2'b00;
      m_araddr[0] = '0;
      m_araddr[1] = '0;
      s_arready   = 1'b0;
      s_rvalid    = 1'b0;
      s_rdata     = '0;
      s_rresp     = 2'b00;
      in_data     = 1'b0;
      gp          = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_data[i] = '0;
         mem_resp[i] = 2'b00;
      end

      //            port addr   ar r  rdy drop data          resp
      vecs[0] = '{0, 4'h4, 1, 1, 0, 1'b0, 32'h0000_0013, 2'b00};
      vecs[1] = '{1, 4'h9, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 2'b00};
      vecs[2] = '{0, 4'h0, 5, 1, 2, 1'b0, 32'hCAFE_F00D, 2'b00};
      vecs[3] = '{1, 4'hF, 0, 1, 0, 1'b0, 32'h1234_5678, 2'b10};
      vecs[4] = '{1, 4'h3, 2, 0, 1, 1'b1, 32'hA5A5_5A5A, 2'b11};
      vecs[5] = '{0, 4'hE, 0, 0, 0, 1'b1, 32'hFFFF_FFFF, 2'b01};

      repeat (2) @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) begin
         sel = 1'(k);
         #1;
         chk("rst_grant", 32'(grant_o), 32'd0);
         chk("rst_busy", 32'(busy_o), 32'd0);
         chk("rst_s_arvalid", 32'(s_arvalid_o), 32'd0);
         chk("rst_s_araddr", 32'(s_araddr_o), 32'd0);
         sample();
      end
      sel  = 1'b0;
      NRST = 1'b1;

      foreach (vecs[i]) begin
         step();
         request(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].resp);
         sample();
         serve_one(vecs[i].port, vecs[i].ar_dly, vecs[i].r_dly, vecs[i].rdy_dly, vecs[i].drop);
      end

      // Simultaneous requests, fixed priority: port 1 first every round
      for (int r = 0; r < 3; r++) begin
         step();
         request(0, AW'(8 + r), 32'hA000_0000 + 32'(r), 2'b00);
         request(1, AW'(1 + r), 32'hB000_0000 + 32'(r), 2'b00);
         sample();
         serve_one(1, 0, 0, 0, 1'b0);
         serve_one(0, 0, 0, 0, 1'b0);
      end

      // Simultaneous requests, round-robin: 0,1,0,1,0,1 from reset
      step();
      sel = 1'b1;
      sample();
      for (int r = 0; r < 3; r++) begin
         step();
         request(0, AW'(8 + r), 32'hC000_0000 + 32'(r), 2'b00);
         request(1, AW'(1 + r), 32'hD000_0000 + 32'(r), 2'b00);
         sample();
         serve_one(0, 0, 1, 0, 1'b0);
         serve_one(1, 1, 0, 0, 1'b0);
      end
      step();
      sel = 1'b0;
      sample();

      // Asynchronous reset while a response is being presented
      step();
      request(0, 4'h6, 32'h6666_0006, 2'b00);
      sample();
      step();
      sample();
      chk("pre_rst_s_arvalid", 32'(s_arvalid_o), 32'd1);
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      in_data   = 1'b1;
      gp        = 1'b0;
      sample();
      step();
      s_rvalid    = 1'b1;
      s_rdata     = mem_data[6];
      s_rresp     = 2'b00;
      m_rready[0] = 1'b0;
      sample();
      #2;
      NRST    = 1'b0;
      in_data = 1'b0;
      sample();
      chk("arst_s_arvalid", 32'(s_arvalid_o), 32'd0);
      chk("arst_s_araddr", 32'(s_araddr_o), 32'd0);
      chk("arst_grant", 32'(grant_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      s_rvalid     = 1'b0;
      s_rdata      = '0;
      m_arvalid[0] = 1'b0;
      chk("abandoned_entries", 32'(exp_q0.size()), 32'd1);
      exp_q0.delete();
      step();
      step();
      NRST = 1'b1;
      step();
      request(0, 4'h7, 32'h7777_0007, 2'b00);
      sample();
      serve_one(0, 1, 0, 0, 1'b0);

      chk("q0_drained", 32'(exp_q0.size()), 32'd0);
      chk("q1_drained", 32'(exp_q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
